alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 93 +++++++++
 tb/tb_alu_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of one shared ALU with a one-entry result register
// Define ALU_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority to requester 0.
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [5:0]          req_op,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [DATA_W-1:0]   rsp_data
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t              state, state_nxt;
  logic                can_accept;
  logic                accept;
  logic                grant_id;
  logic [2:0]          op_sel;
  logic [DATA_W-1:0]   a_sel, b_sel, alu_res;

`ifdef ALU_ARBITER_ROUND_ROBIN_EN
  logic prio;

  // prio names the requester that wins when both are valid
  always_comb begin
    grant_id = req_valid[1];
    if (req_valid == 2'b11) grant_id = prio;
  end
`else
  always_comb begin
    grant_id = ~req_valid[0];
  end
`endif

  always_comb begin
    can_accept = (state == EMPTY) || rsp_ready;
    accept     = rst_n && can_accept && (req_valid != 2'b00);
    req_ready  = 2'b00;
    if (accept) req_ready = grant_id ? 2'b10 : 2'b01;

    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (rsp_ready && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    op_sel  = grant_id ? req_op[5:3] : req_op[2:0];
    a_sel   = grant_id ? req_a[DATA_W +: DATA_W] : req_a[0 +: DATA_W];
    b_sel   = grant_id ? req_b[DATA_W +: DATA_W] : req_b[0 +: DATA_W];
    alu_res = '0;
    case (op_sel)
      3'b000:  alu_res = a_sel + b_sel;
      3'b001:  alu_res = a_sel - b_sel;
      3'b010:  alu_res = a_sel & b_sel;
      3'b011:  alu_res = a_sel | b_sel;
      3'b100:  alu_res = a_sel ^ b_sel;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
      prio     <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        rsp_id   <= grant_id;
        rsp_data <= alu_res;
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
        prio     <= ~grant_id;
`endif
      end
    end
  end

  assign rsp_valid = (state == FULL);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

  localparam int DATA_W = 32;
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [5:0]          req_op;
  logic [2*DATA_W-1:0] req_a;
  logic [2*DATA_W-1:0] req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_id;
  logic [DATA_W-1:0]   rsp_data;

  int n_cmp = 0;
  int n_err = 0;

  alu_arbiter #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (i == 0) begin
      req_op[2:0] = op; req_a[31:0] = a; req_b[31:0] = b;
    end else begin
      req_op[5:3] = op; req_a[63:32] = a; req_b[63:32] = b;
    end
  endtask

  // ends on a falling edge with reset released and nothing requested
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b0;
    #1 check("rst_ready_async", req_ready, 2'b00);
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", req_ready, 2'b00);
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_data", rsp_data, 32'h0);
    check("rst_id", rsp_id, 1'b0);
    rst_n = 1'b1; req_valid = 2'b00;
  endtask

  logic [2:0]  v_op  [7] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b111};
  logic [31:0] v_a   [7] = '{32'hFFFF_FFFF, 32'h3, 32'hF0F0_1234, 32'hF000_000F, 32'h0000_F0F0, 32'h5, 32'h5};
  logic [31:0] v_b   [7] = '{32'h2, 32'h5, 32'h0FF0_FF00, 32'h00F0_0F00, 32'h0000_0FF0, 32'h3, 32'h3};
  logic [31:0] v_exp [7] = '{32'h1, 32'hFFFF_FFFE, 32'h00F0_1200, 32'hF0F0_0F0F, 32'h0000_FF00, 32'h0, 32'h0};

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0;

    do_reset();

    // single requests through both ports, ALU coverage incl. illegal ops
    for (int v = 0; v < 7; v++) begin
      int r;
      r = v % 2;
      set_req(r, v_op[v], v_a[v], v_b[v]);
      req_valid = (r == 0) ? 2'b01 : 2'b10;
      rsp_ready = 1'b1;
      #1 check($sformatf("single_ready_%0d", v), req_ready, (r == 0) ? 2'b01 : 2'b10);
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      check($sformatf("single_valid_%0d", v), rsp_valid, 1'b1);
      check($sformatf("single_id_%0d", v), rsp_id, r[0]);
      check($sformatf("single_data_%0d", v), rsp_data, v_exp[v]);
      @(negedge clk);
      #1 check($sformatf("single_drain_%0d", v), rsp_valid, 1'b0);
    end

    // contention from reset, back-to-back with rsp_ready held high
    do_reset();
    set_req(0, 3'b000, 32'd10, 32'd1);
    set_req(1, 3'b001, 32'd10, 32'd1);
    req_valid = 2'b11; rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic exp_id;
      exp_id = RR_EN ? k[0] : 1'b0;
      #1 check($sformatf("cont_ready_%0d", k), req_ready, exp_id ? 2'b10 : 2'b01);
      @(negedge clk);
      #1;
      check($sformatf("cont_valid_%0d", k), rsp_valid, 1'b1);
      check($sformatf("cont_id_%0d", k), rsp_id, exp_id);
      check($sformatf("cont_data_%0d", k), rsp_data, exp_id ? 32'd9 : 32'd11);
    end
    req_valid = 2'b00;
    @(negedge clk);
    #1 check("cont_drain", rsp_valid, 1'b0);

    // backpressure: result held while a pending request waits
    do_reset();
    set_req(1, 3'b100, 32'h0000_F0F0, 32'h0000_0FF0);
    req_valid = 2'b10; rsp_ready = 1'b0;
    #1 check("bp_first_ready", req_ready, 2'b10);
    @(negedge clk);
    set_req(1, 3'b010, 32'h0000_FF00, 32'h0000_0F00);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_valid_%0d", k), rsp_valid, 1'b1);
      check($sformatf("bp_data_%0d", k), rsp_data, 32'h0000_FF00);
      check($sformatf("bp_id_%0d", k), rsp_id, 1'b1);
      check($sformatf("bp_ready_%0d", k), req_ready, 2'b00);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1 check("bp_release_ready", req_ready, 2'b10);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check("bp_next_valid", rsp_valid, 1'b1);
    check("bp_next_data", rsp_data, 32'h0000_0F00);
    @(negedge clk);
    #1 check("bp_drain", rsp_valid, 1'b0);

    // reset while FULL and stalled
    set_req(1, 3'b000, 32'h1, 32'h1);
    req_valid = 2'b10; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 2'b00;
    #1 check("mid_full", rsp_valid, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_valid", rsp_valid, 1'b0);
    check("mid_data", rsp_data, 32'h0);
    set_req(0, 3'b011, 32'h0000_00A0, 32'h0000_000B);
    req_valid = 2'b11; rsp_ready = 1'b1;
    #1 check("mid_grant", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check("mid_rsp_id", rsp_id, 1'b0);
    check("mid_rsp_data", rsp_data, 32'h0000_00AB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
